// File: rtl/ecc_op_controller.sv
// Operation sequencer for the ECC datapath: runs encode, decode or full-channel
// (encode, noise injection, decode) per CTRL write, with a per-phase watchdog.
module ecc_op_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_wr,
  input  logic [1:0] ctrl,
  input  logic [1:0] cw_width,
  output logic       enc_start,
  input  logic       enc_done,
  output logic       dec_start,
  input  logic       dec_done,
  input  logic [1:0] dec_num_err,
  output logic       dec_src_sel,
  output logic       noise_en,
  output logic [5:0] cw_len,
  output logic       busy,
  output logic       operation_done,
  output logic [1:0] num_of_errors,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, ENC, NOISE, DEC, DONE} state_t;
  typedef enum logic [1:0] {OP_ENC = 2'b00, OP_DEC = 2'b01, OP_FULL = 2'b10} op_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      op             <= OP_ENC;
      wd             <= '0;
      enc_start      <= 1'b0;
      dec_start      <= 1'b0;
      dec_src_sel    <= 1'b0;
      noise_en       <= 1'b0;
      cw_len         <= 6'd8;
      busy           <= 1'b0;
      operation_done <= 1'b0;
      num_of_errors  <= '0;
      err_timeout    <= 1'b0;
    end else begin
      enc_start      <= 1'b0;
      dec_start      <= 1'b0;
      noise_en       <= 1'b0;
      operation_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_wr && ctrl != 2'b11) begin
            op          <= op_t'(ctrl);
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            wd          <= '0;
            dec_src_sel <= 1'b0;
            case (cw_width)
              2'b00:   cw_len <= 6'd8;
              2'b01:   cw_len <= 6'd16;
              default: cw_len <= 6'd32;
            endcase
            if (ctrl == 2'b01) begin
              state     <= DEC;
              dec_start <= 1'b1;
            end else begin
              state     <= ENC;
              enc_start <= 1'b1;
            end
          end
        end
        ENC: begin
          // done is checked before the watchdog so a same-cycle done wins
          if (enc_done) begin
            if (op == OP_FULL) begin
              state       <= NOISE;
              noise_en    <= 1'b1;
              dec_src_sel <= 1'b1;
            end else begin
              state          <= DONE;
              operation_done <= 1'b1;
              num_of_errors  <= 2'b00;
            end
          end else if (wd == WD_LAST) begin
            state          <= DONE;
            operation_done <= 1'b1;
            num_of_errors  <= 2'b11;
            err_timeout    <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        NOISE: begin
          state     <= DEC;
          dec_start <= 1'b1;
          wd        <= '0;
        end
        DEC: begin
          if (dec_done) begin
            state          <= DONE;
            operation_done <= 1'b1;
            num_of_errors  <= dec_num_err;
            dec_src_sel    <= 1'b0;
          end else if (wd == WD_LAST) begin
            state          <= DONE;
            operation_done <= 1'b1;
            num_of_errors  <= 2'b11;
            err_timeout    <= 1'b1;
            dec_src_sel    <= 1'b0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
